// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-VC input stage of a router port.
// A circular FIFO holds incoming flits. The head flit's destination is shown to
// route computation. An IDLE/VA/SA state machine then takes the packet through
// VC allocation and switch allocation.
//
// Flit layout, MSB first: {label[1:0], vc_id[VC_SIZE-1:0], x_dest, y_dest, payload}.
// Label encoding: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
// Port encoding:  LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4.
module input_vc_buffer #(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_SIZE     = 2,
  parameter int DEST_X_W    = 4,
  parameter int DEST_Y_W    = 4,
  parameter int PAYLOAD_W   = 8,
  parameter int PORT_W      = 3,
  localparam int FLIT_W     = 2 + VC_SIZE + DEST_X_W + DEST_Y_W + PAYLOAD_W,
  localparam int PTR_W      = $clog2(BUFFER_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   data_i,
  input  logic                write_i,
  input  logic                read_i,
  input  logic                va_grant_i,
  input  logic [VC_SIZE-1:0]  vc_new_i,
  input  logic [PORT_W-1:0]   out_port_i,
  output logic [DEST_X_W-1:0] x_dest_o,
  output logic [DEST_Y_W-1:0] y_dest_o,
  output logic [FLIT_W-1:0]   data_o,
  output logic [PORT_W-1:0]   out_port_o,
  output logic                vc_request_o,
  output logic                switch_request_o,
  output logic                is_full_o,
  output logic                is_empty_o,
  output logic                error_o
);

  localparam logic [1:0] LBL_HEAD     = 2'd0;
  localparam logic [1:0] LBL_BODY     = 2'd1;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VA   = 2'd1;
  localparam logic [1:0] SA   = 2'd2;

  localparam logic [PORT_W-1:0] PORT_LOCAL = '0;

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = BUFFER_SIZE[PTR_W:0];

  localparam int LBL_MSB = FLIT_W - 1;
  localparam int VC_MSB  = FLIT_W - 3;
  localparam int X_MSB   = DEST_X_W + DEST_Y_W + PAYLOAD_W - 1;
  localparam int Y_MSB   = DEST_Y_W + PAYLOAD_W - 1;
  localparam int LOW_W   = DEST_X_W + DEST_Y_W + PAYLOAD_W;

  logic [FLIT_W-1:0]  mem [BUFFER_SIZE];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic [1:0]         state;
  logic [VC_SIZE-1:0] vc_latched;
  logic               first_flit;

  logic [FLIT_W-1:0]  head;
  logic [1:0]         head_label;
  logic               head_is_head;
  logic               head_ends_pkt;
  logic               idle_drop;
  logic               sa_pop;
  logic               pop;
  logic               push;
  logic               err_now;

  // Head decode and the push/pop/error decisions for this cycle.
  always_comb begin
    head          = mem[rd_ptr];
    head_label    = head[LBL_MSB -: 2];
    head_is_head  = (head_label == LBL_HEAD) || (head_label == LBL_HEADTAIL);
    head_ends_pkt = (head_label == LBL_TAIL) || (head_label == LBL_HEADTAIL);
    // A non-head flit at the front while idle belongs to no packet and is discarded.
    idle_drop     = (state == IDLE) && !is_empty_o && !head_is_head;
    sa_pop        = (state == SA) && read_i && !is_empty_o;
    pop           = idle_drop || sa_pop;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    push          = write_i && (!is_full_o || pop);
    // A HEAD popped after the packet's first flit means a second header inside one packet.
    err_now       = (write_i && !push) || (read_i && !sa_pop) || idle_drop ||
                    (sa_pop && (head_label == LBL_HEAD) && !first_flit);
  end

  // Status and request outputs depend only on state and occupancy.
  always_comb begin
    is_empty_o       = (count == '0);
    is_full_o        = (count == CNT_FULL);
    vc_request_o     = (state == VA);
    switch_request_o = (state == SA) && !is_empty_o;
    x_dest_o         = is_empty_o ? '0 : head[X_MSB -: DEST_X_W];
    y_dest_o         = is_empty_o ? '0 : head[Y_MSB -: DEST_Y_W];
    data_o           = is_empty_o ? '0 : {head_label, vc_latched, head[LOW_W-1:0]};
  end

  // Flit storage. Contents are not reset because occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // Packet sequencing: route latch in IDLE, VC grant in VA, flit forwarding in SA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_port_o <= PORT_LOCAL;
      vc_latched <= '0;
      first_flit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!is_empty_o && head_is_head) begin
            out_port_o <= out_port_i;
            state      <= VA;
          end
        end
        VA: begin
          if (va_grant_i) begin
            vc_latched <= vc_new_i;
            first_flit <= 1'b1;
            state      <= SA;
          end
        end
        SA: begin
          if (sa_pop) begin
            first_flit <= 1'b0;
            if (head_ends_pkt) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         error_o <= 1'b0;
    else if (err_now) error_o <= 1'b1;
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed testbench for input_vc_buffer.
module tb_input_vc_buffer;
  localparam int FW = 20;
  localparam logic [1:0] L_HEAD = 2'd0, L_BODY = 2'd1, L_TAIL = 2'd2, L_HT = 2'd3;
  localparam logic [2:0] P_LOCAL = 3'd0, P_NORTH = 3'd1, P_SOUTH = 3'd2, P_WEST = 3'd3, P_EAST = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic          write_i = 1'b0, read_i = 1'b0, va_grant_i = 1'b0;
  logic [1:0]    vc_new_i = '0;
  logic [2:0]    out_port_i = '0;
  logic [3:0]    x_dest_o, y_dest_o;
  logic [FW-1:0] data_o;
  logic [2:0]    out_port_o;
  logic          vc_request_o, switch_request_o, is_full_o, is_empty_o, error_o;

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] q [$];

  input_vc_buffer dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i), .read_i(read_i),
    .va_grant_i(va_grant_i), .vc_new_i(vc_new_i), .out_port_i(out_port_i),
    .x_dest_o(x_dest_o), .y_dest_o(y_dest_o), .data_o(data_o), .out_port_o(out_port_o),
    .vc_request_o(vc_request_o), .switch_request_o(switch_request_o),
    .is_full_o(is_full_o), .is_empty_o(is_empty_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] l, input logic [1:0] vc,
                                       input logic [3:0] x, input logic [3:0] y, input logic [7:0] p);
    return {l, vc, x, y, p};
  endfunction

  function automatic logic [FW-1:0] setvc(input logic [FW-1:0] f, input logic [1:0] vc);
    logic [FW-1:0] r;
    r = f;
    r[17:16] = vc;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    write_i = 1'b0; read_i = 1'b0; va_grant_i = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    #2;
    checks++; if (is_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", is_empty_o); end
    checks++; if (is_full_o !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", is_full_o); end
    checks++; if (vc_request_o !== 1'b0) begin failures++; $display("FAIL reset_vcreq: got %b want 0", vc_request_o); end
    checks++; if (switch_request_o !== 1'b0) begin failures++; $display("FAIL reset_swreq: got %b want 0", switch_request_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error_o); end
    checks++; if (out_port_o !== P_LOCAL) begin failures++; $display("FAIL reset_port: got %0d want %0d", out_port_o, P_LOCAL); end
    checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", data_o); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++; if (is_empty_o !== 1'b1 || vc_request_o !== 1'b0) begin failures++; $display("FAIL reset_hold: empty=%b vcreq=%b want 1/0", is_empty_o, vc_request_o); end
  endtask

  task automatic test_packet;
    logic [FW-1:0] f [3];
    f[0] = mk(L_HEAD, 2'd3, 4'd4, 4'd2, 8'hA0);
    f[1] = mk(L_BODY, 2'd3, 4'd5, 4'd6, 8'hA1);
    f[2] = mk(L_TAIL, 2'd3, 4'd7, 4'd8, 8'hA2);
    out_port_i = P_EAST;
    data_i = f[0]; write_i = 1'b1; tick();
    checks++; if (is_empty_o !== 1'b0) begin failures++; $display("FAIL pkt_empty: got %b want 0", is_empty_o); end
    checks++; if (vc_request_o !== 1'b0) begin failures++; $display("FAIL pkt_vcreq_early: got %b want 0", vc_request_o); end
    checks++; if (x_dest_o !== 4'd4 || y_dest_o !== 4'd2) begin failures++; $display("FAIL pkt_dest: got x=%0d y=%0d want 4 2", x_dest_o, y_dest_o); end
    data_i = f[1]; tick();
    checks++; if (vc_request_o !== 1'b1) begin failures++; $display("FAIL pkt_vcreq: got %b want 1", vc_request_o); end
    checks++; if (out_port_o !== P_EAST) begin failures++; $display("FAIL pkt_port: got %0d want %0d", out_port_o, P_EAST); end
    data_i = f[2]; tick(); write_i = 1'b0;
    checks++; if (vc_request_o !== 1'b1 || switch_request_o !== 1'b0) begin failures++; $display("FAIL pkt_va_wait: vcreq=%b swreq=%b want 1/0", vc_request_o, switch_request_o); end
    va_grant_i = 1'b1; vc_new_i = 2'd1; tick(); va_grant_i = 1'b0;
    checks++; if (switch_request_o !== 1'b1 || vc_request_o !== 1'b0) begin failures++; $display("FAIL pkt_sa: swreq=%b vcreq=%b want 1/0", switch_request_o, vc_request_o); end
    read_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_o !== setvc(f[i], 2'd1)) begin failures++; $display("FAIL pkt_data%0d: got %h want %h", i, data_o, setvc(f[i], 2'd1)); end
      tick();
    end
    read_i = 1'b0;
    checks++; if (is_empty_o !== 1'b1 || switch_request_o !== 1'b0 || data_o !== '0) begin failures++; $display("FAIL pkt_done: empty=%b swreq=%b data=%h want 1/0/0", is_empty_o, switch_request_o, data_o); end
    tick();
    checks++; if (vc_request_o !== 1'b0 || error_o !== 1'b0) begin failures++; $display("FAIL pkt_idle: vcreq=%b err=%b want 0/0", vc_request_o, error_o); end
  endtask

  task automatic test_headtail;
    logic [FW-1:0] f;
    f = mk(L_HT, 2'd0, 4'd2, 4'd0, 8'h55);
    out_port_i = P_NORTH;
    data_i = f; write_i = 1'b1; tick(); write_i = 1'b0;
    checks++; if (x_dest_o !== 4'd2 || y_dest_o !== 4'd0) begin failures++; $display("FAIL ht_dest: got x=%0d y=%0d want 2 0", x_dest_o, y_dest_o); end
    tick();
    checks++; if (vc_request_o !== 1'b1 || out_port_o !== P_NORTH) begin failures++; $display("FAIL ht_va: vcreq=%b port=%0d want 1/%0d", vc_request_o, out_port_o, P_NORTH); end
    va_grant_i = 1'b1; vc_new_i = 2'd2; tick(); va_grant_i = 1'b0;
    checks++; if (switch_request_o !== 1'b1 || data_o !== setvc(f, 2'd2)) begin failures++; $display("FAIL ht_sa: swreq=%b data=%h want 1/%h", switch_request_o, data_o, setvc(f, 2'd2)); end
    read_i = 1'b1; tick(); read_i = 1'b0;
    checks++; if (is_empty_o !== 1'b1 || switch_request_o !== 1'b0 || vc_request_o !== 1'b0) begin failures++; $display("FAIL ht_idle: empty=%b swreq=%b vcreq=%b want 1/0/0", is_empty_o, switch_request_o, vc_request_o); end
    tick();
    checks++; if (vc_request_o !== 1'b0 || error_o !== 1'b0) begin failures++; $display("FAIL ht_after: vcreq=%b err=%b want 0/0", vc_request_o, error_o); end
  endtask

  task automatic test_full;
    logic [FW-1:0] f;
    do_reset();
    q.delete();
    out_port_i = P_WEST;
    write_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f = mk((i == 0) ? L_HEAD : L_BODY, 2'd0, 4'd1, 4'd1, 8'(i));
      data_i = f; q.push_back(setvc(f, 2'd3));
      tick();
    end
    write_i = 1'b0;
    checks++; if (is_full_o !== 1'b1 || error_o !== 1'b0) begin failures++; $display("FAIL full_set: full=%b err=%b want 1/0", is_full_o, error_o); end
    data_i = mk(L_BODY, 2'd0, 4'd0, 4'd0, 8'hFF); write_i = 1'b1; tick(); write_i = 1'b0;
    checks++; if (error_o !== 1'b1 || is_full_o !== 1'b1) begin failures++; $display("FAIL full_drop: err=%b full=%b want 1/1", error_o, is_full_o); end
    va_grant_i = 1'b1; vc_new_i = 2'd3; tick(); va_grant_i = 1'b0;
    checks++; if (switch_request_o !== 1'b1) begin failures++; $display("FAIL full_sa: swreq=%b want 1", switch_request_o); end
    for (int k = 0; k < 20; k++) begin
      f = mk((k == 19) ? L_TAIL : L_BODY, 2'd0, 4'd2, 4'd2, 8'(8 + k));
      data_i = f; write_i = 1'b1; read_i = 1'b1;
      q.push_back(setvc(f, 2'd3));
      f = q.pop_front();
      checks++; if (data_o !== f) begin failures++; $display("FAIL full_order%0d: got %h want %h", k, data_o, f); end
      tick();
      checks++; if (is_full_o !== 1'b1) begin failures++; $display("FAIL full_keep%0d: full=%b want 1", k, is_full_o); end
    end
    write_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      f = q.pop_front();
      checks++; if (data_o !== f) begin failures++; $display("FAIL full_drain%0d: got %h want %h", k, data_o, f); end
      tick();
    end
    read_i = 1'b0;
    checks++; if (is_empty_o !== 1'b1 || switch_request_o !== 1'b0 || vc_request_o !== 1'b0) begin failures++; $display("FAIL full_end: empty=%b swreq=%b vcreq=%b want 1/0/0", is_empty_o, switch_request_o, vc_request_o); end
  endtask

  task automatic test_body_idle;
    logic [FW-1:0] f;
    do_reset();
    data_i = mk(L_BODY, 2'd0, 4'd9, 4'd9, 8'h33); write_i = 1'b1; tick(); write_i = 1'b0;
    checks++; if (is_empty_o !== 1'b0 || error_o !== 1'b0) begin failures++; $display("FAIL body_stored: empty=%b err=%b want 0/0", is_empty_o, error_o); end
    tick();
    checks++; if (error_o !== 1'b1 || is_empty_o !== 1'b1 || vc_request_o !== 1'b0) begin failures++; $display("FAIL body_drop: err=%b empty=%b vcreq=%b want 1/1/0", error_o, is_empty_o, vc_request_o); end
    f = mk(L_HEAD, 2'd0, 4'd3, 4'd1, 8'h77);
    out_port_i = P_SOUTH;
    data_i = f; write_i = 1'b1; tick(); write_i = 1'b0;
    tick();
    checks++; if (vc_request_o !== 1'b1 || out_port_o !== P_SOUTH) begin failures++; $display("FAIL body_next_va: vcreq=%b port=%0d want 1/%0d", vc_request_o, out_port_o, P_SOUTH); end
    checks++; if (x_dest_o !== 4'd3 || y_dest_o !== 4'd1) begin failures++; $display("FAIL body_next_dest: got x=%0d y=%0d want 3 1", x_dest_o, y_dest_o); end
    va_grant_i = 1'b1; vc_new_i = 2'd1; tick(); va_grant_i = 1'b0;
    checks++; if (switch_request_o !== 1'b1 || data_o !== setvc(f, 2'd1) || error_o !== 1'b1) begin failures++; $display("FAIL body_next_sa: swreq=%b data=%h err=%b want 1/%h/1", switch_request_o, data_o, error_o, setvc(f, 2'd1)); end
  endtask

  task automatic test_reset_mid;
    logic [FW-1:0] f;
    do_reset();
    out_port_i = P_EAST;
    write_i = 1'b1;
    data_i = mk(L_HEAD, 2'd0, 4'd6, 4'd6, 8'h01); tick();
    data_i = mk(L_BODY, 2'd0, 4'd6, 4'd6, 8'h02); tick();
    data_i = mk(L_BODY, 2'd0, 4'd6, 4'd6, 8'h03); va_grant_i = 1'b1; vc_new_i = 2'd3; tick();
    idle_inputs();
    checks++; if (switch_request_o !== 1'b1 || out_port_o !== P_EAST) begin failures++; $display("FAIL mid_sa: swreq=%b port=%0d want 1/%0d", switch_request_o, out_port_o, P_EAST); end
    #2 rst = 1'b0;
    #1;
    checks++; if (is_empty_o !== 1'b1 || is_full_o !== 1'b0 || switch_request_o !== 1'b0 || vc_request_o !== 1'b0) begin failures++; $display("FAIL mid_async_status: empty=%b full=%b swreq=%b vcreq=%b want 1/0/0/0", is_empty_o, is_full_o, switch_request_o, vc_request_o); end
    checks++; if (out_port_o !== P_LOCAL || data_o !== '0 || error_o !== 1'b0) begin failures++; $display("FAIL mid_async_regs: port=%0d data=%h err=%b want 0/0/0", out_port_o, data_o, error_o); end
    #3 rst = 1'b1;
    tick();
    f = mk(L_HEAD, 2'd2, 4'd1, 4'd3, 8'h44);
    out_port_i = P_NORTH;
    data_i = f; write_i = 1'b1; tick(); write_i = 1'b0;
    checks++; if (x_dest_o !== 4'd1 || y_dest_o !== 4'd3 || data_o !== setvc(f, 2'd0)) begin failures++; $display("FAIL mid_new_head: x=%0d y=%0d data=%h want 1 3 %h", x_dest_o, y_dest_o, data_o, setvc(f, 2'd0)); end
    tick();
    checks++; if (vc_request_o !== 1'b1 || out_port_o !== P_NORTH) begin failures++; $display("FAIL mid_new_route: vcreq=%b port=%0d want 1/%0d", vc_request_o, out_port_o, P_NORTH); end
  endtask

  task automatic test_back_to_back;
    logic [FW-1:0] h1, t1, h2, t2;
    do_reset();
    h1 = mk(L_HEAD, 2'd0, 4'd1, 4'd1, 8'h10);
    t1 = mk(L_TAIL, 2'd0, 4'd1, 4'd1, 8'h11);
    h2 = mk(L_HEAD, 2'd0, 4'd2, 4'd2, 8'h20);
    t2 = mk(L_TAIL, 2'd0, 4'd2, 4'd2, 8'h21);
    out_port_i = P_WEST;
    write_i = 1'b1;
    data_i = h1; tick();
    data_i = t1; tick();
    checks++; if (vc_request_o !== 1'b1 || out_port_o !== P_WEST) begin failures++; $display("FAIL b2b_first_va: vcreq=%b port=%0d want 1/%0d", vc_request_o, out_port_o, P_WEST); end
    out_port_i = P_SOUTH;
    data_i = h2; va_grant_i = 1'b1; vc_new_i = 2'd1; tick(); va_grant_i = 1'b0;
    checks++; if (switch_request_o !== 1'b1 || data_o !== setvc(h1, 2'd1)) begin failures++; $display("FAIL b2b_first_sa: swreq=%b data=%h want 1/%h", switch_request_o, data_o, setvc(h1, 2'd1)); end
    data_i = t2; read_i = 1'b1; tick();
    checks++; if (data_o !== setvc(t1, 2'd1)) begin failures++; $display("FAIL b2b_tail1: got %h want %h", data_o, setvc(t1, 2'd1)); end
    write_i = 1'b0; tick(); read_i = 1'b0;
    checks++; if (vc_request_o !== 1'b0 || switch_request_o !== 1'b0 || out_port_o !== P_WEST || is_empty_o !== 1'b0) begin failures++; $display("FAIL b2b_bubble: vcreq=%b swreq=%b port=%0d empty=%b want 0/0/%0d/0", vc_request_o, switch_request_o, out_port_o, is_empty_o, P_WEST); end
    tick();
    checks++; if (vc_request_o !== 1'b1 || out_port_o !== P_SOUTH) begin failures++; $display("FAIL b2b_second_va: vcreq=%b port=%0d want 1/%0d", vc_request_o, out_port_o, P_SOUTH); end
    va_grant_i = 1'b1; vc_new_i = 2'd2; tick(); va_grant_i = 1'b0;
    checks++; if (switch_request_o !== 1'b1 || data_o !== setvc(h2, 2'd2)) begin failures++; $display("FAIL b2b_second_sa: swreq=%b data=%h want 1/%h", switch_request_o, data_o, setvc(h2, 2'd2)); end
    read_i = 1'b1; tick(); tick(); read_i = 1'b0;
    checks++; if (is_empty_o !== 1'b1 || error_o !== 1'b0 || switch_request_o !== 1'b0) begin failures++; $display("FAIL b2b_end: empty=%b err=%b swreq=%b want 1/0/0", is_empty_o, error_o, switch_request_o); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_headtail();
    test_full();
    test_body_idle();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
